// File: rtl/key_judge.sv
// Piano-tiles per-beat hit judge: synchronises beat clock, keys and running,
// judges key edges inside each beat window and tracks misses, lives and game over.

module key_judge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic lvl,
   output logic prv
);
   logic meta;

   // two flops for metastability, third flop holds the previous level for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         lvl  <= 1'b0;
         prv  <= 1'b0;
      end else begin
         meta <= d;
         lvl  <= meta;
         prv  <= lvl;
      end
   end
endmodule

module key_judge #(
   parameter int LIVES         = 3,
   parameter bit MISS_ON_EMPTY = 1'b1
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       running,
   input  logic       game_clock,
   input  logic [3:0] press_raw,
   input  logic       tile_valid,
   input  logic [1:0] expected_lane,
   output logic       correct_key_pressed,
   output logic       miss_pulse,
   output logic [1:0] lives_left,
   output logic       game_over
);
   localparam logic [1:0] LIVES_INIT = 2'(LIVES);

   typedef enum logic [2:0] {IDLE, WAIT, WINDOW, HIT, FAIL, OVER} state_t;
   state_t state, next_state;

   logic       run_lvl, run_prv, gc_lvl, gc_prv;
   logic [3:0] key_lvl, key_prv, key_rise;
   logic       run_rise, gc_rise, gc_fall;
   logic       key_any, key_hit, key_bad, beat_start, fail_entry;
   logic       tile_q, ckp_q, miss_q;
   logic [1:0] lane_q, lives_q;

   key_judge_sync u_run_sync (.clk(CLOCK_50), .rst_n(resetn), .d(running),
                              .lvl(run_lvl), .prv(run_prv));
   key_judge_sync u_gc_sync  (.clk(CLOCK_50), .rst_n(resetn), .d(game_clock),
                              .lvl(gc_lvl), .prv(gc_prv));

   generate
      for (genvar i = 0; i < 4; i++) begin : g_key
         key_judge_sync u_key_sync (.clk(CLOCK_50), .rst_n(resetn), .d(press_raw[i]),
                                    .lvl(key_lvl[i]), .prv(key_prv[i]));
      end
   endgenerate

   assign run_rise = run_lvl & ~run_prv;
   assign gc_rise  = gc_lvl & ~gc_prv;
   assign gc_fall  = ~gc_lvl & gc_prv;
   assign key_rise = key_lvl & ~key_prv;
   assign key_any  = |key_rise;
   // a hit needs exactly one rising lane, and it must be the tile's lane
   assign key_hit  = tile_q && (key_rise == (4'd1 << lane_q));
   assign key_bad  = key_any && !key_hit && (tile_q || MISS_ON_EMPTY);

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (!run_lvl) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:   if (run_rise) next_state = WAIT;
            WAIT:   if (gc_rise)  next_state = WINDOW;
            WINDOW: begin
               // window close wins over a key edge arriving in the same cycle
               if (gc_fall)      next_state = tile_q ? FAIL : WAIT;
               else if (key_hit) next_state = HIT;
               else if (key_bad) next_state = FAIL;
            end
            HIT:    if (!gc_lvl) next_state = WAIT;
            FAIL: begin
               if (lives_q == 2'd0) next_state = OVER;
               else if (!gc_lvl)    next_state = WAIT;
            end
            OVER:   next_state = OVER;
            default: next_state = IDLE;
         endcase
      end
   end

   assign beat_start = (state == WAIT) && (next_state == WINDOW);
   assign fail_entry = (state != FAIL) && (next_state == FAIL);

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         tile_q  <= 1'b0;
         lane_q  <= 2'd0;
         ckp_q   <= 1'b0;
         miss_q  <= 1'b0;
         lives_q <= LIVES_INIT;
      end else begin
         miss_q <= fail_entry;
         if (beat_start) begin
            tile_q <= tile_valid;
            lane_q <= expected_lane;
         end
         if (next_state == IDLE)
            lives_q <= LIVES_INIT;
         else if (fail_entry && lives_q != 2'd0)
            lives_q <= lives_q - 2'd1;
         // credit holds through the low phase so the score counter sees it at the fall
         if (next_state == IDLE || next_state == OVER || beat_start)
            ckp_q <= 1'b0;
         else if (state == WINDOW && next_state == HIT)
            ckp_q <= 1'b1;
      end
   end

   always_comb begin
      correct_key_pressed = ckp_q;
      miss_pulse          = miss_q;
      lives_left          = lives_q;
      game_over           = (state == OVER);
   end
endmodule

// File: tb/tb_key_judge.sv
// Bench for key_judge: directed table, hand sequences for latency/held key/reset,
// and random beats checked against a beat-level model of the judging rules.
`timescale 1ns/1ps
module tb_key_judge;
   localparam int H = 40;

   typedef int         offs_t[4];
   typedef logic [3:0] msk_t[4];
   typedef struct {
      logic       tv;
      logic [1:0] ln;
      logic [3:0] msk;
      int         off;
      int         ckp;
      int         miss1;
      int         lives1;
      int         miss0;
      int         lives0;
   } vec_t;

   logic       clk = 1'b0;
   logic       resetn, running, game_clock, tile_valid;
   logic [3:0] press_raw;
   logic [1:0] expected_lane;
   logic       ckp1, miss1, go1, ckp0, miss0, go0;
   logic [1:0] lives1, lives0;
   int         checks = 0, errors = 0;
   int         mcnt1 = 0, mcnt0 = 0;

   vec_t  tbl[8];
   offs_t offs;
   msk_t  msk;
   int    m1, m0, r1, r0, ec1, em1, ec0, em0, ml1, ml0, n, o;
   bit    ov1, ov0;
   logic  rtv;
   logic [1:0] rln;

   always #5 clk = ~clk;

   key_judge #(.LIVES(3), .MISS_ON_EMPTY(1'b1)) dut (
      .CLOCK_50(clk), .resetn(resetn), .running(running), .game_clock(game_clock),
      .press_raw(press_raw), .tile_valid(tile_valid), .expected_lane(expected_lane),
      .correct_key_pressed(ckp1), .miss_pulse(miss1), .lives_left(lives1), .game_over(go1));

   key_judge #(.LIVES(3), .MISS_ON_EMPTY(1'b0)) dut0 (
      .CLOCK_50(clk), .resetn(resetn), .running(running), .game_clock(game_clock),
      .press_raw(press_raw), .tile_valid(tile_valid), .expected_lane(expected_lane),
      .correct_key_pressed(ckp0), .miss_pulse(miss0), .lives_left(lives0), .game_over(go0));

   always @(negedge clk) begin
      if (miss1) mcnt1++;
      if (miss0) mcnt0++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic restart();
      running = 1'b0; game_clock = 1'b0; press_raw = 4'd0;
      step(5);
      running = 1'b1;
      step(6);
   endtask

   // One beat: tile set in the low phase, high phase of H cycles, events at offsets from the raw rise.
   task automatic beat(input logic tv, input logic [1:0] ln, input int ne, input offs_t of,
                       input msk_t mk, input bit keep, output int d1, output int d0);
      int b1, b0;
      tile_valid = tv; expected_lane = ln;
      step(3);
      b1 = mcnt1; b0 = mcnt0;
      game_clock = 1'b1;
      for (int c = 1; c <= H + 6; c++) begin
         step(1);
         if (c == H) game_clock = 1'b0;
         for (int e = 0; e < ne; e++) begin
            if (of[e] == c) press_raw = press_raw | mk[e];
            if (!keep && of[e] + 2 == c) press_raw = press_raw & ~mk[e];
         end
      end
      d1 = mcnt1 - b1; d0 = mcnt0 - b0;
   endtask

   // Outcome of a beat from the rules: 0 nothing, 1 hit, 2 miss. The earliest judged event decides.
   function automatic int judge(input logic tv, input logic [1:0] ln, input int ne,
                                input offs_t of, input msk_t mk, input bit moe);
      int first, best;
      logic [3:0] want;
      first = -1; best = 1 << 30;
      for (int e = 0; e < ne; e++)
         if (of[e] >= 1 && of[e] < H && of[e] < best) begin
            best = of[e]; first = e;
         end
      if (first < 0) return tv ? 2 : 0;
      if (!tv) return moe ? 2 : 0;
      want = 4'b0001 << ln;
      return (mk[first] == want) ? 1 : 2;
   endfunction

   task automatic model(input int res, inout int lives, inout bit over, output int eckp, output int emiss);
      eckp = 0; emiss = 0;
      if (over) return;
      if (res == 1) eckp = 1;
      if (res == 2) begin
         emiss = 1;
         lives--;
         if (lives == 0) over = 1'b1;
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 2'd2, 4'b0100, 20, 1, 0, 3, 0, 3};
      tbl[1] = '{1'b1, 2'd2, 4'b0010, 20, 0, 1, 2, 1, 2};
      tbl[2] = '{1'b1, 2'd0, 4'b0101, 20, 0, 1, 2, 1, 2};
      tbl[3] = '{1'b1, 2'd3, 4'b0000,  0, 0, 1, 2, 1, 2};
      tbl[4] = '{1'b0, 2'd0, 4'b0001, 20, 0, 1, 2, 0, 3};
      tbl[5] = '{1'b0, 2'd1, 4'b0000,  0, 0, 0, 3, 0, 3};
      tbl[6] = '{1'b1, 2'd1, 4'b0010, 36, 1, 0, 3, 0, 3};
      tbl[7] = '{1'b1, 2'd1, 4'b0010, 40, 0, 1, 2, 1, 2};

      resetn = 1'b0; running = 1'b0; game_clock = 1'b0; press_raw = 4'd0;
      tile_valid = 1'b0; expected_lane = 2'd0;
      offs = '{0, 0, 0, 0}; msk = '{4'd0, 4'd0, 4'd0, 4'd0};
      step(3);
      check("rst_ckp", ckp1, 0);
      check("rst_miss", miss1, 0);
      check("rst_lives", lives1, 3);
      check("rst_over", go1, 0);
      resetn = 1'b1;
      step(2);

      for (int i = 0; i < 8; i++) begin
         restart();
         offs[0] = tbl[i].off; msk[0] = tbl[i].msk;
         beat(tbl[i].tv, tbl[i].ln, (tbl[i].msk != 4'd0) ? 1 : 0, offs, msk, 1'b0, m1, m0);
         check($sformatf("tbl%0d_ckp", i), ckp1, tbl[i].ckp);
         check($sformatf("tbl%0d_miss", i), m1, tbl[i].miss1);
         check($sformatf("tbl%0d_lives", i), lives1, tbl[i].lives1);
         check($sformatf("tbl%0d_ckp0", i), ckp0, tbl[i].ckp);
         check($sformatf("tbl%0d_miss0", i), m0, tbl[i].miss0);
         check($sformatf("tbl%0d_lives0", i), lives0, tbl[i].lives0);
      end

      // hit latency, hold through the low phase, clear at next beat start, then timeout latency
      restart();
      tile_valid = 1'b1; expected_lane = 2'd2;
      step(3);
      game_clock = 1'b1;
      step(50);
      press_raw = 4'b0100;
      step(2); check("hit_early", ckp1, 0);
      step(1); check("hit_latency", ckp1, 1);
      press_raw = 4'd0;
      step(47); game_clock = 1'b0;
      step(8);
      check("hit_held_low", ckp1, 1);
      check("hit_lives", lives1, 3);
      game_clock = 1'b1;
      step(2); check("hit_held_prerise", ckp1, 1);
      step(1); check("hit_clear_rise", ckp1, 0);
      step(20); game_clock = 1'b0;
      step(2); check("tmo_early", miss1, 0);
      step(1); check("tmo_latency", miss1, 1);
      step(1); check("tmo_pulse_end", miss1, 0);
      check("tmo_lives", lives1, 2);

      // wrong lane then right lane in one window
      restart();
      offs = '{10, 20, 0, 0}; msk = '{4'b0010, 4'b0100, 4'd0, 4'd0};
      beat(1'b1, 2'd2, 2, offs, msk, 1'b0, m1, m0);
      check("wr_miss", m1, 1);
      check("wr_lives", lives1, 2);
      check("wr_ckp", ckp1, 0);

      // key held across beats must not re-trigger
      restart();
      offs = '{20, 0, 0, 0}; msk = '{4'b0001, 4'd0, 4'd0, 4'd0};
      beat(1'b1, 2'd0, 1, offs, msk, 1'b1, m1, m0);
      check("held_first_ckp", ckp1, 1);
      beat(1'b1, 2'd0, 0, offs, msk, 1'b0, m1, m0);
      check("held_second_ckp", ckp1, 0);
      check("held_second_miss", m1, 1);
      press_raw = 4'd0;

      // three timeouts exhaust lives; OVER then ignores a correct press
      restart();
      for (int i = 0; i < 3; i++) begin
         beat(1'b1, 2'd3, 0, offs, msk, 1'b0, m1, m0);
         check($sformatf("to%0d_miss", i), m1, 1);
         check($sformatf("to%0d_lives", i), lives1, 2 - i);
         check($sformatf("to%0d_over", i), go1, (i == 2) ? 1 : 0);
      end
      offs = '{20, 0, 0, 0}; msk = '{4'b1000, 4'd0, 4'd0, 4'd0};
      beat(1'b1, 2'd3, 1, offs, msk, 1'b0, m1, m0);
      check("over_ckp", ckp1, 0);
      check("over_miss", m1, 0);
      check("over_lives", lives1, 0);
      check("over_hold", go1, 1);
      running = 1'b0;
      step(4);
      check("over_exit_go", go1, 0);
      check("over_exit_lives", lives1, 3);
      running = 1'b1;
      step(6);
      check("restart_go", go1, 0);
      check("restart_lives", lives1, 3);

      // asynchronous reset in the middle of a HIT
      restart();
      offs = '{20, 0, 0, 0}; msk = '{4'b0010, 4'd0, 4'd0, 4'd0};
      beat(1'b1, 2'd0, 1, offs, msk, 1'b0, m1, m0);
      tile_valid = 1'b1; expected_lane = 2'd1;
      step(3);
      game_clock = 1'b1;
      step(10); press_raw = 4'b0010;
      step(4);
      check("pre_rst_ckp", ckp1, 1);
      check("pre_rst_lives", lives1, 2);
      resetn = 1'b0;
      #1;
      check("midrst_ckp", ckp1, 0);
      check("midrst_lives", lives1, 3);
      check("midrst_miss", miss1, 0);
      check("midrst_go", go1, 0);
      game_clock = 1'b0; press_raw = 4'd0;
      step(2);
      resetn = 1'b1;
      step(2);

      // random beats against the rule model
      restart();
      ml1 = 3; ml0 = 3; ov1 = 1'b0; ov0 = 1'b0;
      for (int b = 0; b < 40; b++) begin
         rtv = ($urandom_range(0, 3) != 0);
         rln = 2'($urandom_range(0, 3));
         n = $urandom_range(0, 3);
         o = 2 + $urandom_range(0, 3);
         for (int e = 0; e < 4; e++) begin
            offs[e] = o;
            msk[e]  = $urandom_range(0, 1) ? (4'b0001 << rln) : 4'($urandom_range(1, 15));
            o = o + 4 + $urandom_range(0, 6);
         end
         beat(rtv, rln, n, offs, msk, 1'b0, m1, m0);
         r1 = judge(rtv, rln, n, offs, msk, 1'b1);
         r0 = judge(rtv, rln, n, offs, msk, 1'b0);
         model(r1, ml1, ov1, ec1, em1);
         model(r0, ml0, ov0, ec0, em0);
         check($sformatf("rnd%0d_ckp", b), ckp1, ec1);
         check($sformatf("rnd%0d_miss", b), m1, em1);
         check($sformatf("rnd%0d_lives", b), lives1, ml1);
         check($sformatf("rnd%0d_over", b), go1, ov1);
         check($sformatf("rnd%0d_ckp0", b), ckp0, ec0);
         check($sformatf("rnd%0d_miss0", b), m0, em0);
         check($sformatf("rnd%0d_lives0", b), lives0, ml0);
         check($sformatf("rnd%0d_over0", b), go0, ov0);
         if (ov1 || ov0) begin
            restart();
            ml1 = 3; ml0 = 3; ov1 = 1'b0; ov0 = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_judge.md
# key_judge

Per-beat hit judge for the piano-tiles game; it is the producer side of the `correct_key_pressed` / `running` handshake that the score counter consumes. It watches the player's four lane keys during each beat's judgement window and compares them against the tile lane supplied by the tile generator. It drives a level `correct_key_pressed` that is stable across the falling edge of `game_clock`, where the score counter samples it. It also tracks misses, remaining lives, and game-over.

## Interface
- `LIVES`, 3: misses allowed before game over; legal range 1..3.
- `MISS_ON_EMPTY`, 1: 1 = any press during a tile-less beat costs a life; 0 = such presses are ignored.

- `CLOCK_50` input 1: system clock, 50 MHz; all state is in this domain.
- `resetn` input 1: asynchronous, active-low reset.
- `running` input 1: game-active level from the score block.
- `game_clock` input 1: beat clock.
  - High phase = judgement window.
  - Falling edge = score sample point.
  - Asynchronous to `CLOCK_50`.
- `press_raw` input 4: player lane keys, active-high, asynchronous, not debounced upstream.
- `tile_valid` input 1: the current beat carries a tile; quasi-static, changes only while `game_clock` is low.
- `expected_lane` input 2: lane of the current tile; same timing as `tile_valid`.
- `correct_key_pressed` output 1: level; current beat was hit.
- `miss_pulse` output 1: one-cycle pulse when a life is lost.
- `lives_left` output 2: remaining lives.
- `game_over` output 1: level; lives are exhausted.

## Operation
- Synchronisation:
  - `game_clock`, `press_raw`, and `running` each pass through 2 flip-flops.
  - Edge detect compares the synchronised value against a third flip-flop.
  - `tile_valid` and `expected_lane` are captured on the synchronised rising edge of `game_clock` (beat start).
- Only rising edges of synchronised keys count. A key held across beats never re-triggers.
- State machine:
  - IDLE: outputs are cleared and `lives_left` = LIVES. Go to WAIT when `running` rises. Any state returns to IDLE within 1 cycle of `running` falling.
  - WAIT: `game_clock` is low; key edges are ignored. On the synchronised rise of `game_clock`, capture the tile, clear `correct_key_pressed`, and go to WINDOW.
  - WINDOW: evaluate key edges each cycle.
    - Exactly one edge, on lane `expected_lane`, with `tile_valid` set: go to HIT.
    - Any other edge set (wrong lane, multiple lanes in one cycle, or any edge with `tile_valid` = 0 and `MISS_ON_EMPTY` = 1): go to FAIL.
    - On the synchronised fall of `game_clock`: if `tile_valid` = 1, go to FAIL; otherwise go to WAIT.
  - HIT: `correct_key_pressed` = 1. Further key edges are ignored for the rest of the beat. On the synchronised fall, go to WAIT. `correct_key_pressed` stays high until the next beat start.
  - FAIL: on entry, pulse `miss_pulse` for 1 cycle and decrement `lives_left`. Once `lives_left` reaches 0, go to OVER; otherwise ignore edges until the synchronised fall, then go to WAIT.
  - OVER: `game_over` = 1 and `correct_key_pressed` = 0; `lives_left` holds 0. Leave only via `running` low or reset.
- `lives_left` saturates at 0 and never wraps.
- A key edge in the same cycle as the synchronised `game_clock` fall is ignored; the close takes priority.

## Timing
- Reset values: `correct_key_pressed` = 0, `miss_pulse` = 0, `game_over` = 0, `lives_left` = LIVES, state IDLE, all synchronisers 0.
- Key latency: 3 `CLOCK_50` cycles from a raw key rise to `correct_key_pressed` or `miss_pulse`.
- Window-close latency: 3 cycles from a raw `game_clock` fall to a timeout `miss_pulse`.
- Guaranteed credit: a press at least 4 cycles before the raw `game_clock` fall is reflected at the score sample point.
- `correct_key_pressed` changes only in WINDOW (0 to 1), at beat start (1 to 0), or on entry to IDLE/OVER.
- Reset mid-beat clears everything immediately. `running` must re-rise before any judging resumes.

## Test plan
- Hit: `tile_valid` = 1, `expected_lane` = 2; raw `press_raw[2]` rises 50 cycles into a 100-cycle high phase → `correct_key_pressed` = 1 three cycles later, held until the next rise; `lives_left` stays 3.
- Wrong lane then right lane: `press_raw[1]`, then `press_raw[2]` in the same window → `miss_pulse` once, `lives_left` = 2, `correct_key_pressed` stays 0.
- Timeout: no press during a tile beat → `miss_pulse` 3 cycles after the raw fall. Three consecutive such beats → `lives_left` 2, 1, 0, and `game_over` = 1.
- Chord and held key: lanes 0 and 2 rise in the same cycle with `expected_lane` = 0 → FAIL. A key held high from the previous beat produces no hit.
- Empty beat: `tile_valid` = 0 with a press → miss when `MISS_ON_EMPTY` = 1; no effect when it is 0. No press → no miss for either setting.
- Reset and restart: `resetn` low mid-HIT → all outputs clear at once. `running` toggled 0 then 1 from OVER → `lives_left` = 3, `game_over` = 0.
